pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: RUN/MEMWAIT/HALTED FSM driving latch enables and bubble flushes.
// Optional front-end stall counter on port stall_cnt, enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter int LU_BUBBLES = 1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic [4:0] dec_rs,
    input  logic [4:0] dec_rt,
    input  logic       ex_memRen,
    input  logic       ex_regWen,
    input  logic [4:0] ex_regDest,
    input  logic       ex_brTaken,
    input  logic       mem_memRen,
    input  logic       mem_memWen,
    input  logic       wb_halt,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       halt
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] MEMWAIT = 2'd1;
    localparam logic [1:0] HALTED  = 2'd2;

    // Enable bit order: {pc, ifid, idex, exmem, memwb}.
    localparam logic [4:0] EN_ALL = 5'b11111;
    localparam logic [4:0] EN_LU  = 5'b00111;
    localparam logic [4:0] EN_IM  = 5'b01111;

    logic [1:0] state_reg, state_next;
    logic [1:0] bub_reg, bub_next;
    logic       halt_reg;
    logic [4:0] en_vec;
    logic       ifid_flush_next, idex_flush_next;
    logic       mem_busy, lu_hit;

    assign mem_busy = (mem_memRen | mem_memWen) & ~dhit;
    assign lu_hit   = ex_memRen & ex_regWen & (ex_regDest != 5'd0) &
                      ((ex_regDest == dec_rs) | (ex_regDest == dec_rt));

    always_comb begin
        state_next      = state_reg;
        bub_next        = bub_reg;
        en_vec          = 5'b00000;
        ifid_flush_next = 1'b0;
        idex_flush_next = 1'b0;
        if (nRST) begin
            case (state_reg)
                HALTED: begin
                end
                MEMWAIT: begin
                    // Bubble counter stays frozen across the whole wait, including the release cycle.
                    if (dhit) begin
                        en_vec     = EN_ALL;
                        state_next = RUN;
                    end
                end
                default: begin
                    if (wb_halt) begin
                        state_next = HALTED;
                    end else if (mem_busy) begin
                        state_next = MEMWAIT;
                    end else if (bub_reg != 2'd0) begin
                        en_vec          = EN_LU;
                        idex_flush_next = 1'b1;
                        bub_next        = bub_reg - 2'd1;
                    end else if (lu_hit) begin
                        en_vec          = EN_LU;
                        idex_flush_next = 1'b1;
                        bub_next        = 2'(LU_BUBBLES - 1);
                    end else if (ex_brTaken) begin
                        en_vec          = EN_ALL;
                        ifid_flush_next = 1'b1;
                        idex_flush_next = 1'b1;
                        bub_next        = 2'd0;
                    end else if (!ihit) begin
                        en_vec          = EN_IM;
                        ifid_flush_next = 1'b1;
                    end else begin
                        en_vec = EN_ALL;
                    end
                end
            endcase
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en_vec;
    assign ifid_flush = ifid_flush_next & ifid_en;
    assign idex_flush = idex_flush_next & idex_en;
    // Gated so the flag reads 0 for the whole time reset is held, not only after the edge.
    assign halt       = halt_reg & nRST;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg <= RUN;
            bub_reg   <= 2'd0;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            bub_reg   <= bub_next;
            halt_reg  <= (state_next == HALTED);
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_reg <= 32'd0;
        end else if (!pc_en && (state_reg != HALTED) && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver pushes expected outputs per cycle, a monitor pops and compares.
`timescale 1ns/1ps
module tb_pipeline_ctrl;

    localparam int LUB = 2;

    // Expected vector: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halt}
    localparam logic [7:0] NORM  = 8'b11111_00_0;
    localparam logic [7:0] OFF   = 8'b00000_00_0;
    localparam logic [7:0] LU    = 8'b00111_01_0;
    localparam logic [7:0] BR    = 8'b11111_11_0;
    localparam logic [7:0] IMISS = 8'b01111_10_0;
    localparam logic [7:0] HLT   = 8'b00000_00_1;

    logic CLK = 1'b1;
    logic nRST, ihit, dhit, ex_memRen, ex_regWen, ex_brTaken, mem_memRen, mem_memWen, wb_halt;
    logic [4:0] dec_rs, dec_rt, ex_regDest;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_item_t;
    sb_item_t sb_q[$];

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.LU_BUBBLES(LUB)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dec_rs(dec_rs), .dec_rt(dec_rt),
        .ex_memRen(ex_memRen), .ex_regWen(ex_regWen), .ex_regDest(ex_regDest),
        .ex_brTaken(ex_brTaken), .mem_memRen(mem_memRen), .mem_memWen(mem_memWen),
        .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halt(halt)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Inputs are applied at the falling edge, so expectations describe the cycle ending at the next rising edge.
    task automatic cyc(input logic [7:0] exp, input string name);
        sb_item_t it;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
        @(negedge CLK);
    endtask

    task automatic clear_hazard();
        ex_memRen = 1'b0; ex_regWen = 1'b0; ex_regDest = 5'd0;
        dec_rs = 5'd0; dec_rt = 5'd0; ex_brTaken = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt);
        ex_memRen = 1'b1; ex_regWen = 1'b1; ex_regDest = dest; dec_rs = rs; dec_rt = rt;
    endtask

    initial begin : monitor
        sb_item_t it;
        logic [7:0] act;
        forever begin
            @(negedge CLK);
            #2;
            if (sb_q.size() > 0) begin
                it  = sb_q.pop_front();
                act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt};
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got=%b want=%b", it.name, act, it.exp);
                end else begin
                    $display("ok   %s: %b", it.name, act);
                end
            end
        end
    end

    initial begin : driver
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b1; mem_memRen = 1'b0; mem_memWen = 1'b0; wb_halt = 1'b0;
        clear_hazard();
        ex_brTaken = 1'b1;
        @(negedge CLK);

        cyc(OFF, "reset_held_0");
        ihit = 1'b1; ex_brTaken = 1'b0;
        cyc(OFF, "reset_held_1");
        nRST = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) cyc(NORM, "normal_after_reset");

        // Load-use via rs: one detection cycle plus one repeated bubble.
        set_load(5'd5, 5'd5, 5'd0);
        cyc(LU, "lu_rs_detect");
        clear_hazard();
        cyc(LU, "lu_rs_repeat");
        cyc(NORM, "lu_rs_done");
        set_load(5'd7, 5'd1, 5'd7);
        cyc(LU, "lu_rt_detect");
        clear_hazard();
        cyc(LU, "lu_rt_repeat");
        cyc(NORM, "lu_rt_done");
        set_load(5'd0, 5'd0, 5'd0);
        cyc(NORM, "lu_r0_ignored");
        set_load(5'd9, 5'd9, 5'd0);
        ex_memRen = 1'b0;
        cyc(NORM, "non_load_no_stall");
        clear_hazard();

        // Data memory wait: three stalled cycles then release.
        mem_memRen = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) cyc(OFF, "memwait_stall");
        dhit = 1'b1;
        cyc(NORM, "memwait_release");
        mem_memRen = 1'b0; dhit = 1'b0;
        cyc(NORM, "memwait_back_run");
        mem_memWen = 1'b1; dhit = 1'b1;
        cyc(NORM, "dhit_in_run_no_stall");
        mem_memWen = 1'b0; dhit = 1'b0;

        // Bubble counter freezes across a memory stall, and no new hazard is detected meanwhile.
        set_load(5'd3, 5'd3, 5'd0);
        cyc(LU, "freeze_detect");
        mem_memRen = 1'b1;
        cyc(OFF, "freeze_memstall");
        dhit = 1'b1;
        cyc(NORM, "freeze_release");
        clear_hazard();
        mem_memRen = 1'b0; dhit = 1'b0;
        cyc(LU, "freeze_bubble_resumes");
        cyc(NORM, "freeze_done");

        // Branch beats ihit miss; ihit miss alone.
        ex_brTaken = 1'b1; ihit = 1'b0;
        cyc(BR, "branch_with_imiss");
        ex_brTaken = 1'b0;
        cyc(IMISS, "imiss");
        ihit = 1'b1;
        cyc(NORM, "imiss_recover");

        // Fresh reset, then 4 fetch misses and one load-use hazard for the stall counter.
        nRST = 1'b0;
        cyc(OFF, "reset_for_count");
        nRST = 1'b1; ihit = 1'b0;
        for (int i = 0; i < 4; i++) cyc(IMISS, "count_imiss");
        ihit = 1'b1;
        set_load(5'd5, 5'd5, 5'd0);
        cyc(LU, "count_lu_detect");
        clear_hazard();
        cyc(LU, "count_lu_repeat");
`ifdef PIPE_PERF_CNT_EN
        total++;
        if (stall_cnt !== 32'(4 + LUB)) begin
            bad++;
            $display("FAIL stall_cnt: got=%0d want=%0d", stall_cnt, 4 + LUB);
        end else begin
            $display("ok   stall_cnt: %0d", stall_cnt);
        end
`endif
        cyc(NORM, "count_done");

        // Reset in the middle of a memory wait returns straight to RUN.
        mem_memRen = 1'b1; dhit = 1'b0;
        cyc(OFF, "rst_memwait_enter");
        nRST = 1'b0;
        cyc(OFF, "rst_memwait_reset");
        nRST = 1'b1; mem_memRen = 1'b0;
        cyc(NORM, "rst_memwait_run");

        // Halt: the wb_halt cycle is frozen, then HALTED persists regardless of inputs.
        wb_halt = 1'b1;
        cyc(OFF, "halt_entry");
        wb_halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ihit = i[0]; dhit = ~i[0]; mem_memRen = i[1]; ex_brTaken = i[2];
            cyc(HLT, "halted_hold");
        end
        ihit = 1'b1; dhit = 1'b0; mem_memRen = 1'b0; ex_brTaken = 1'b0;
        nRST = 1'b0;
        cyc(OFF, "halt_reset");
        nRST = 1'b1;
        cyc(NORM, "after_halt_reset");

        #3;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d left want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
